rvfi_trace_gen: RTL and testbench

- Synthesizable RVFI retirement-trace source: the transmitting end of the RVFI interface that the rvfi_*_check modules consume.
- Emits up to NRET retirements per cycle with strictly increasing rvfi_order and a self-consistent PC chain.
  - Each instruction's pc_rdata equals the previous instruction's pc_wdata.
- Used as a known-good or known-bad stimulus source to validate checkers (pc_bwd, pc_fwd, causal) standalone, without a core.

---
 rtl/rvfi_trace_gen.sv | 147 ++++++++++++++
 tb/tb_rvfi_trace_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_gen.sv
// RVFI retirement-trace source: emits up to NRET retirements per cycle with a consistent PC chain.
// Optional macro RVFI_TRACE_GEN_FAULT_EN adds fault_inject, which corrupts slot 0 pc_rdata to break one link.
module rvfi_trace_gen #(
  parameter int XLEN = 32,
  parameter int NRET = 2,
  parameter int CW   = $clog2(NRET + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 stall,
  input  logic [XLEN-1:0]      pc_seed,
  input  logic [CW-1:0]        ret_count,
  input  logic                 br_valid,
  input  logic [CW-1:0]        br_slot,
  input  logic [XLEN-1:0]      br_target,
  input  logic [63:0]          limit,
`ifdef RVFI_TRACE_GEN_FAULT_EN
  input  logic                 fault_inject,
`endif
  output logic [NRET-1:0]      rvfi_valid,
  output logic [64*NRET-1:0]   rvfi_order,
  output logic [XLEN*NRET-1:0] rvfi_pc_rdata,
  output logic [XLEN*NRET-1:0] rvfi_pc_wdata,
  output logic [32*NRET-1:0]   rvfi_insn,
  output logic                 rvfi_rollback_valid,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t            state;
  logic [63:0]       next_order;
  logic [XLEN-1:0]   next_pc;

  logic [CW-1:0]        k_req;
  logic [CW-1:0]        k;
  logic [63:0]          remaining;
  logic                 limit_hit;
  logic [XLEN-1:0]      chain_pc;
  logic [XLEN-1:0]      slot_wdata;
  logic [NRET-1:0]      iss_valid;
  logic [64*NRET-1:0]   iss_order;
  logic [XLEN*NRET-1:0] iss_pc_rdata;
  logic [XLEN*NRET-1:0] iss_pc_wdata;
  logic [32*NRET-1:0]   iss_insn;
  logic [XLEN*NRET-1:0] fault_bus;

  assign rvfi_rollback_valid = 1'b0;

  // Issue width is the smallest of request, channel count and what is left under the limit.
  always_comb begin
    k_req     = (ret_count > CW'(NRET)) ? CW'(NRET) : ret_count;
    remaining = limit - next_order;
    limit_hit = (limit != 64'd0) && (next_order >= limit);
    k         = k_req;
    if (limit_hit)
      k = '0;
    else if ((limit != 64'd0) && (remaining < 64'(k_req)))
      k = remaining[CW-1:0];

    chain_pc     = next_pc;
    slot_wdata   = '0;
    iss_valid    = '0;
    iss_order    = '0;
    iss_pc_rdata = '0;
    iss_pc_wdata = '0;
    iss_insn     = '0;
    for (int i = 0; i < NRET; i++) begin
      if (CW'(i) < k) begin
        iss_valid[i]                 = 1'b1;
        iss_order[64*i +: 64]        = next_order + 64'(i);
        iss_pc_rdata[XLEN*i +: XLEN] = chain_pc;
        if (br_valid && (br_slot == CW'(i))) begin
          slot_wdata           = br_target & ~XLEN'(1);
          iss_insn[32*i +: 32] = 32'h0000006F;
        end else begin
          slot_wdata           = chain_pc + XLEN'(4);
          iss_insn[32*i +: 32] = 32'h00000013;
        end
        iss_pc_wdata[XLEN*i +: XLEN] = slot_wdata;
        chain_pc                     = slot_wdata;
      end
    end

    // The corruption touches only the emitted value, never next_pc, so exactly one link breaks.
    fault_bus = '0;
`ifdef RVFI_TRACE_GEN_FAULT_EN
    if (fault_inject && (k != '0))
      fault_bus[XLEN-1:0] = XLEN'(4);
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      next_order    <= '0;
      next_pc       <= '0;
      rvfi_valid    <= '0;
      rvfi_order    <= '0;
      rvfi_pc_rdata <= '0;
      rvfi_pc_wdata <= '0;
      rvfi_insn     <= '0;
      done          <= 1'b0;
    end else begin
      rvfi_valid    <= '0;
      rvfi_order    <= '0;
      rvfi_pc_rdata <= '0;
      rvfi_pc_wdata <= '0;
      rvfi_insn     <= '0;
      case (state)
        IDLE: begin
          if (enable) begin
            next_pc <= pc_seed;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= PAUSE;
          end else if (limit_hit) begin
            state <= DONE;
          end else if (!stall && (k != '0)) begin
            rvfi_valid    <= iss_valid;
            rvfi_order    <= iss_order;
            rvfi_pc_rdata <= iss_pc_rdata ^ fault_bus;
            rvfi_pc_wdata <= iss_pc_wdata;
            rvfi_insn     <= iss_insn;
            next_order    <= next_order + 64'(k);
            next_pc       <= chain_pc;
            if ((limit != 64'd0) && ((next_order + 64'(k)) == limit))
              state <= DONE;
          end
        end
        PAUSE: begin
          if (enable)
            state <= RUN;
        end
        DONE: begin
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_trace_gen.sv
// Directed, table-driven bench for rvfi_trace_gen (NRET=2, XLEN=32).
module tb_rvfi_trace_gen;
  localparam int XLEN = 32;
  localparam int NRET = 2;
  localparam int CW   = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 stall;
  logic [XLEN-1:0]      pc_seed;
  logic [CW-1:0]        ret_count;
  logic                 br_valid;
  logic [CW-1:0]        br_slot;
  logic [XLEN-1:0]      br_target;
  logic [63:0]          limit;
`ifdef RVFI_TRACE_GEN_FAULT_EN
  logic                 fault_inject = 1'b0;
`endif
  logic [NRET-1:0]      rvfi_valid;
  logic [64*NRET-1:0]   rvfi_order;
  logic [XLEN*NRET-1:0] rvfi_pc_rdata;
  logic [XLEN*NRET-1:0] rvfi_pc_wdata;
  logic [32*NRET-1:0]   rvfi_insn;
  logic                 rvfi_rollback_valid;
  logic                 done;

  int checks = 0;
  int errors = 0;

  rvfi_trace_gen #(.XLEN(XLEN), .NRET(NRET), .CW(CW)) dut (
    .clock               (clock),
    .reset               (reset),
    .enable              (enable),
    .stall               (stall),
    .pc_seed             (pc_seed),
    .ret_count           (ret_count),
    .br_valid            (br_valid),
    .br_slot             (br_slot),
    .br_target           (br_target),
    .limit               (limit),
`ifdef RVFI_TRACE_GEN_FAULT_EN
    .fault_inject        (fault_inject),
`endif
    .rvfi_valid          (rvfi_valid),
    .rvfi_order          (rvfi_order),
    .rvfi_pc_rdata       (rvfi_pc_rdata),
    .rvfi_pc_wdata       (rvfi_pc_wdata),
    .rvfi_insn           (rvfi_insn),
    .rvfi_rollback_valid (rvfi_rollback_valid),
    .done                (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic        st;
    logic [1:0]  rc;
    logic        bv;
    logic [1:0]  bs;
    logic [31:0] bt;
    logic [1:0]  ev;
    logic [63:0] eo0;
    logic [31:0] er0, ew0, ei0;
    logic [63:0] eo1;
    logic [31:0] er1, ew1, ei1;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_slots(input string tag, input logic [1:0] ev,
                           input logic [63:0] eo0, input logic [31:0] er0, input logic [31:0] ew0, input logic [31:0] ei0,
                           input logic [63:0] eo1, input logic [31:0] er1, input logic [31:0] ew1, input logic [31:0] ei1,
                           input logic edone);
    chk({tag, ".valid"},    128'(rvfi_valid),          128'(ev));
    chk({tag, ".order"},    128'(rvfi_order),          {eo1, eo0});
    chk({tag, ".pc_rdata"}, 128'(rvfi_pc_rdata),       128'({er1, er0}));
    chk({tag, ".pc_wdata"}, 128'(rvfi_pc_wdata),       128'({ew1, ew0}));
    chk({tag, ".insn"},     128'(rvfi_insn),           128'({ei1, ei0}));
    chk({tag, ".done"},     128'(done),                128'(edone));
    chk({tag, ".rollback"}, 128'(rvfi_rollback_valid), 128'(1'b0));
  endtask

  task automatic chk_zero(input string tag, input logic edone);
    chk_slots(tag, 2'b00, 64'd0, 32'h0, 32'h0, 32'h0, 64'd0, 32'h0, 32'h0, 32'h0, edone);
  endtask

  initial begin
    // en st rc bv bs bt | valid | slot0 order/rdata/wdata/insn | slot1 order/rdata/wdata/insn
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 2'b00, 64'd0, 32'h0, 32'h0, 32'h0, 64'd0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 2'b11, 64'd0, 32'h1000, 32'h1004, 32'h13, 64'd1, 32'h1004, 32'h1008, 32'h13};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 2'b11, 64'd2, 32'h1008, 32'h100C, 32'h13, 64'd3, 32'h100C, 32'h1010, 32'h13};
    vecs[3]  = '{1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0, 2'b00, 64'd0, 32'h0, 32'h0, 32'h0, 64'd0, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0, 2'b00, 64'd0, 32'h0, 32'h0, 32'h0, 64'd0, 32'h0, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 32'h0, 2'b01, 64'd4, 32'h1010, 32'h1014, 32'h13, 64'd0, 32'h0, 32'h0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 1'b1, 2'd0, 32'h2001, 2'b11, 64'd5, 32'h1014, 32'h2000, 32'h6F, 64'd6, 32'h2000, 32'h2004, 32'h13};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b1, 2'd1, 32'h3000, 2'b01, 64'd7, 32'h2004, 32'h2008, 32'h13, 64'd0, 32'h0, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0, 2'b00, 64'd0, 32'h0, 32'h0, 32'h0, 64'd0, 32'h0, 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 2'b00, 64'd0, 32'h0, 32'h0, 32'h0, 64'd0, 32'h0, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 2'b00, 64'd0, 32'h0, 32'h0, 32'h0, 64'd0, 32'h0, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 32'h0, 2'b11, 64'd8, 32'h2008, 32'h200C, 32'h13, 64'd9, 32'h200C, 32'h2010, 32'h13};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 1'b1, 2'd1, 32'hFFFFFFFF, 2'b11, 64'd10, 32'h2010, 32'h2014, 32'h13, 64'd11, 32'h2014, 32'hFFFFFFFE, 32'h6F};
    vecs[13] = '{1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 2'b11, 64'd12, 32'hFFFFFFFE, 32'h2, 32'h13, 64'd13, 32'h2, 32'h6, 32'h13};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 32'h8000, 2'b00, 64'd0, 32'h0, 32'h0, 32'h0, 64'd0, 32'h0, 32'h0, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 32'h0, 2'b01, 64'd14, 32'h6, 32'hA, 32'h13, 64'd0, 32'h0, 32'h0, 32'h0};

    reset     = 1'b0;
    enable    = 1'b1;
    stall     = 1'b0;
    pc_seed   = 32'h1000;
    ret_count = 2'd2;
    br_valid  = 1'b0;
    br_slot   = 2'd0;
    br_target = 32'h0;
    limit     = 64'd0;

    // Reset held with enable=1: everything stays quiet.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_zero($sformatf("reset%0d", c), 1'b0);
    end
    reset = 1'b1;

    // Unlimited run; pc_seed changes while paused and must not be picked up.
    for (int i = 0; i < 16; i++) begin
      enable    = vecs[i].en;
      stall     = vecs[i].st;
      ret_count = vecs[i].rc;
      br_valid  = vecs[i].bv;
      br_slot   = vecs[i].bs;
      br_target = vecs[i].bt;
      if (i >= 8) pc_seed = 32'h5000;
      tick();
      chk_slots($sformatf("vec%0d", i), vecs[i].ev,
                vecs[i].eo0, vecs[i].er0, vecs[i].ew0, vecs[i].ei0,
                vecs[i].eo1, vecs[i].er1, vecs[i].ew1, vecs[i].ei1, 1'b0);
    end

    // Limit of 5 with two-wide requests: 2,2,1 then done.
    br_valid = 1'b0; enable = 1'b1; stall = 1'b0; ret_count = 2'd2;
    reset = 1'b0;
    tick();
    reset = 1'b1; limit = 64'd5; pc_seed = 32'h100;
    tick();
    chk_zero("lim_start", 1'b0);
    tick();
    chk_slots("lim_a", 2'b11, 64'd0, 32'h100, 32'h104, 32'h13, 64'd1, 32'h104, 32'h108, 32'h13, 1'b0);
    tick();
    chk_slots("lim_b", 2'b11, 64'd2, 32'h108, 32'h10C, 32'h13, 64'd3, 32'h10C, 32'h110, 32'h13, 1'b0);
    tick();
    chk_slots("lim_c", 2'b01, 64'd4, 32'h110, 32'h114, 32'h13, 64'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    chk_zero("lim_done0", 1'b1);
    tick();
    chk_zero("lim_done1", 1'b1);

    // Reset clears done; then a mid-run reset restarts from the new seed at order 0.
    reset = 1'b0;
    tick();
    chk_zero("done_clr", 1'b0);
    reset = 1'b1; limit = 64'd0; pc_seed = 32'h100;
    tick();
    tick();
    chk_slots("pre_rst", 2'b11, 64'd0, 32'h100, 32'h104, 32'h13, 64'd1, 32'h104, 32'h108, 32'h13, 1'b0);
    reset = 1'b0; pc_seed = 32'h4000;
    tick();
    chk_zero("mid_rst", 1'b0);
    reset = 1'b1;
    tick();
    chk_zero("restart_idle", 1'b0);
    tick();
    chk_slots("restart_a", 2'b11, 64'd0, 32'h4000, 32'h4004, 32'h13, 64'd1, 32'h4004, 32'h4008, 32'h13, 1'b0);
    tick();
    tick();
    chk_slots("restart_c", 2'b11, 64'd4, 32'h4010, 32'h4014, 32'h13, 64'd5, 32'h4014, 32'h4018, 32'h13, 1'b0);
`ifdef RVFI_TRACE_GEN_FAULT_EN
    fault_inject = 1'b1;
    tick();
    chk_slots("fault", 2'b11, 64'd6, 32'h401C, 32'h401C, 32'h13, 64'd7, 32'h401C, 32'h4020, 32'h13, 1'b0);
    fault_inject = 1'b0;
`else
    tick();
    chk_slots("order6", 2'b11, 64'd6, 32'h4018, 32'h401C, 32'h13, 64'd7, 32'h401C, 32'h4020, 32'h13, 1'b0);
`endif
    tick();
    chk_slots("order8", 2'b11, 64'd8, 32'h4020, 32'h4024, 32'h13, 64'd9, 32'h4024, 32'h4028, 32'h13, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
